// File: rtl/telemetry_pkg.sv
// rtl/telemetry_pkg.sv - shared constants and FSM state type for the telemetry frame format
// Shared by the telemetry transmitter and receiver.
//   DELIM1/DELIM2 : the two frame delimiter bytes (0xAA, 0x55)
//   PAYLOAD_BYTES : number of payload bytes following the delimiters
//   telem_state_t : receiver FSM states
package telemetry_pkg;

    localparam logic [7:0] DELIM1        = 8'hAA;
    localparam logic [7:0] DELIM2        = 8'h55;
    localparam int         PAYLOAD_BYTES = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D2 = 2'd1,
        PAYLOAD = 2'd2
    } telem_state_t;

endpackage

// File: rtl/telemetry_rcv_if.sv
// rtl/telemetry_rcv_if.sv - byte handshake between UART_rcv and telemetry_rcv
// Signals:
//   rx_data [7:0] : received byte, valid while rx_rdy=1
//   rx_rdy        : byte-available flag from UART_rcv
//   clr_rdy       : consume strobe back to UART_rcv
// Modports: master = UART_rcv side, slave = telemetry_rcv side.
interface telemetry_rcv_if;

    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       clr_rdy;

    modport master (
        output rx_data,
        output rx_rdy,
        input  clr_rdy
    );

    modport slave (
        input  rx_data,
        input  rx_rdy,
        output clr_rdy
    );

endinterface

// File: rtl/telemetry_rcv.sv
// rtl/telemetry_rcv.sv - reassembles 8-byte telemetry frames into batt_v/avg_curr/avg_torque
// Optional feature macro: TELEM_TIMEOUT_EN (adds TIMEOUT_CYC inter-byte timeout).
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   rx         : byte handshake from UART_rcv (telemetry_rcv_if.slave)
//   batt_v     : last good battery voltage (12 bits)
//   avg_curr   : last good average current (12 bits)
//   avg_torque : last good average torque (12 bits)
//   pkt_vld    : one-cycle pulse per good frame
//   frm_err    : one-cycle pulse per rejected frame
module telemetry_rcv
    import telemetry_pkg::*;
`ifdef TELEM_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 1_000_000
)
`endif
(
    input  logic                 clk,
    input  logic                 rst_n,
    telemetry_rcv_if.slave       rx,
    output logic [11:0]          batt_v,
    output logic [11:0]          avg_curr,
    output logic [11:0]          avg_torque,
    output logic                 pkt_vld,
    output logic                 frm_err
);

    telem_state_t state;
    logic [2:0]   cnt;
    logic [11:0]  sh_batt;
    logic [11:0]  sh_curr;
    logic [3:0]   sh_torq_hi;
    logic         last_byte;
    logic         hi_nibble_bad;

    // Every presented byte is consumed on the same edge, so UART_rcv drops rdy next cycle.
    assign rx.clr_rdy = rx.rx_rdy & rst_n;

    assign last_byte     = (cnt == 3'(PAYLOAD_BYTES - 1));
    // Even payload bytes carry only the upper nibble of a 12-bit word.
    assign hi_nibble_bad = !cnt[0] && (rx.rx_data[7:4] != 4'h0);

`ifdef TELEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || rx.rx_rdy || state == IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sh_batt    <= '0;
            sh_curr    <= '0;
            sh_torq_hi <= '0;
            batt_v     <= '0;
            avg_curr   <= '0;
            avg_torque <= '0;
            pkt_vld    <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            pkt_vld <= 1'b0;
            frm_err <= 1'b0;
            if (rx.rx_rdy) begin
                case (state)
                    IDLE: begin
                        if (rx.rx_data == DELIM1) begin
                            state <= WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        if (rx.rx_data == DELIM2) begin
                            state <= PAYLOAD;
                            cnt   <= '0;
                        end else if (rx.rx_data != DELIM1) begin
                            // A repeated 0xAA keeps us here so a frame can resync.
                            state   <= IDLE;
                            frm_err <= 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        if (hi_nibble_bad) begin
                            state   <= IDLE;
                            frm_err <= 1'b1;
                        end else begin
                            cnt <= cnt + 3'd1;
                            case (cnt)
                                3'd0: sh_batt[11:8] <= rx.rx_data[3:0];
                                3'd1: sh_batt[7:0]  <= rx.rx_data;
                                3'd2: sh_curr[11:8] <= rx.rx_data[3:0];
                                3'd3: sh_curr[7:0]  <= rx.rx_data;
                                3'd4: sh_torq_hi    <= rx.rx_data[3:0];
                                default: begin
                                    // Last byte: publish all three words on one edge.
                                    if (last_byte) begin
                                        batt_v     <= sh_batt;
                                        avg_curr   <= sh_curr;
                                        avg_torque <= {sh_torq_hi, rx.rx_data};
                                        pkt_vld    <= 1'b1;
                                    end
                                    state <= IDLE;
                                end
                            endcase
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
`ifdef TELEM_TIMEOUT_EN
            else if (tmo_hit) begin
                state   <= IDLE;
                frm_err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_telemetry_rcv.sv
// tb/tb_telemetry_rcv.sv - scoreboard testbench for telemetry_rcv
module tb_telemetry_rcv;

    logic        clk;
    logic        rst_n;
    logic [11:0] batt_v;
    logic [11:0] avg_curr;
    logic [11:0] avg_torque;
    logic        pkt_vld;
    logic        frm_err;

    telemetry_rcv_if rx_if ();

    typedef struct {
        bit          is_pkt;
        logic [11:0] b;
        logic [11:0] c;
        logic [11:0] t;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [11:0] m_b = 12'h000;
    logic [11:0] m_c = 12'h000;
    logic [11:0] m_t = 12'h000;

`ifdef TELEM_TIMEOUT_EN
    telemetry_rcv #(.TIMEOUT_CYC(100)) dut (
`else
    telemetry_rcv dut (
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx_if.slave),
        .batt_v     (batt_v),
        .avg_curr   (avg_curr),
        .avg_torque (avg_torque),
        .pkt_vld    (pkt_vld),
        .frm_err    (frm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (pkt_vld === 1'b1 || frm_err === 1'b1)) begin
            check("pulse_exclusive", {31'd0, pkt_vld & frm_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, pkt_vld, frm_err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, pkt_vld}, {31'd0, e.is_pkt});
                check("batt_v", {20'd0, batt_v}, {20'd0, e.b});
                check("avg_curr", {20'd0, avg_curr}, {20'd0, e.c});
                check("avg_torque", {20'd0, avg_torque}, {20'd0, e.t});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_if.rx_data = b;
        rx_if.rx_rdy  = 1'b1;
        #1;
        check("clr_rdy_hi", {31'd0, rx_if.clr_rdy}, 32'd1);
        @(negedge clk);
        rx_if.rx_rdy  = 1'b0;
    endtask

    task automatic push_pkt(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        exp_t e;
        m_b = b; m_c = c; m_t = t;
        e.is_pkt = 1'b1; e.b = b; e.c = c; e.t = t;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_pkt = 1'b0; e.b = m_b; e.c = m_c; e.t = m_t;
        exp_q.push_back(e);
    endtask

    task automatic send_payload(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        send_byte({4'h0, b[11:8]}); send_byte(b[7:0]);
        send_byte({4'h0, c[11:8]}); send_byte(c[7:0]);
        send_byte({4'h0, t[11:8]}); send_byte(t[7:0]);
    endtask

    task automatic send_frame(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        push_pkt(b, c, t);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_payload(b, c, t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        rx_if.rx_data = 8'hAA;
        rx_if.rx_rdy  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_clr_rdy", {31'd0, rx_if.clr_rdy}, 32'd0);
        check("rst_batt", {20'd0, batt_v}, 32'd0);
        check("rst_curr", {20'd0, avg_curr}, 32'd0);
        check("rst_torq", {20'd0, avg_torque}, 32'd0);
        check("rst_pulses", {30'd0, pkt_vld, frm_err}, 32'd0);
        rx_if.rx_rdy = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);

        // Basic frame.
        send_frame(12'hABC, 12'h123, 12'h567);

        // Second frame: outputs must hold until its last byte.
        push_pkt(12'h001, 12'hFFF, 12'h800);
        send_byte(8'hAA); send_byte(8'h55);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h0F); send_byte(8'hFF);
        send_byte(8'h08);
        check("hold_batt", {20'd0, batt_v}, 32'h0ABC);
        check("hold_curr", {20'd0, avg_curr}, 32'h0123);
        check("hold_torq", {20'd0, avg_torque}, 32'h0567);
        send_byte(8'h00);

        // Junk byte ignored, double 0xAA resyncs.
        push_pkt(12'h3C5, 12'h0A0, 12'hF0F);
        send_byte(8'h12); send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55);
        send_payload(12'h3C5, 12'h0A0, 12'hF0F);

        // Bad upper nibble on first payload byte.
        push_err();
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h1A);
        send_frame(12'h123, 12'h456, 12'h789);

        // Bad second delimiter.
        push_err();
        send_byte(8'hAA); send_byte(8'h33);

        // Bad upper nibble on payload byte 4 (torque high).
        push_err();
        send_byte(8'hAA); send_byte(8'h55);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hF0);
        send_frame(12'hFFF, 12'h000, 12'h00F);

        // Reset mid-frame after payload byte 3.
        send_byte(8'hAA); send_byte(8'h55);
        send_byte(8'h0D); send_byte(8'hEF); send_byte(8'h0A);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_batt", {20'd0, batt_v}, 32'd0);
        check("midrst_curr", {20'd0, avg_curr}, 32'd0);
        check("midrst_torq", {20'd0, avg_torque}, 32'd0);
        rst_n = 1'b1;
        m_b = 12'h000; m_c = 12'h000; m_t = 12'h000;
        send_frame(12'h7FF, 12'h000, 12'hABC);

`ifdef TELEM_TIMEOUT_EN
        push_err();
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0A);
        repeat (110) @(negedge clk);
        send_frame(12'h246, 12'h8AC, 12'h135);
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/telemetry_rcv.md
Name: telemetry_rcv

Overview:
Downstream consumer of the telemetry UART stream, sitting behind UART_rcv on the receive side. It reassembles 8-byte telemetry frames (0xAA, 0x55, then six payload bytes) back into the 12-bit batt_v, avg_curr and avg_torque words. It checks delimiters and payload format, updates all three outputs together, and pulses pkt_vld once per good frame.

Parameters:
- DELIM1, 8'hAA, first frame delimiter byte.
- DELIM2, 8'h55, second frame delimiter byte.
- TIMEOUT_CYC, 1_000_000, inter-byte timeout in clk cycles; used only when TELEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- rx_data  in  8  byte from UART_rcv; valid while rx_rdy=1.
- rx_rdy  in  1  byte-available flag from UART_rcv.
- clr_rdy  out  1  consume strobe to UART_rcv.
- batt_v  out  12  last good battery voltage.
- avg_curr  out  12  last good average current.
- avg_torque  out  12  last good average torque.
- pkt_vld  out  1  one-cycle pulse per good frame.
- frm_err  out  1  one-cycle pulse per rejected frame.

Behaviour:
- Reset: one clock, synchronous active-low reset on rst_n; no asynchronous reset anywhere.
- Reset values: state=IDLE; byte count=0; batt_v, avg_curr, avg_torque=12'h000; pkt_vld=0; frm_err=0.
- Byte acceptance:
  - A byte is accepted on any clk edge with rx_rdy=1 (and rst_n=1).
  - clr_rdy = rx_rdy & rst_n, combinational, so each byte is consumed exactly once and UART_rcv drops rdy the next cycle.
- States: IDLE, WAIT_D2, PAYLOAD.
- IDLE:
  - Accepted byte == DELIM1 -> WAIT_D2.
  - Any other byte is silently discarded; no frm_err.
- WAIT_D2:
  - Byte == DELIM2 -> PAYLOAD with cnt=0.
  - Byte == DELIM1 -> stay in WAIT_D2 (resync on a repeated 0xAA).
  - Any other byte -> IDLE and frm_err pulse.
- PAYLOAD:
  - cnt 0..5 selects the shadow field: 0=batt_v[11:8], 1=batt_v[7:0], 2=avg_curr[11:8], 3=avg_curr[7:0], 4=avg_torque[11:8], 5=avg_torque[7:0].
  - On even cnt, rx_data[7:4] must be 4'h0. Otherwise go to IDLE, pulse frm_err, and leave the shadow registers unused.
  - On cnt=5 acceptance, copy the shadow registers into all three outputs together on the same edge, assert pkt_vld for that one following cycle, and go to IDLE.
- Outputs never show a partial frame; they hold their values between good frames.
- Latency: outputs and pkt_vld are valid in the cycle after the 6th payload byte is accepted.
- pkt_vld and frm_err are mutually exclusive and each lasts exactly one cycle.
- Back-to-back frames: after cnt=5 the block is in IDLE immediately and accepts the next frame's 0xAA on the very next rx_rdy.
- Reset mid-frame: the FSM returns to IDLE and outputs clear to 0; bytes already in flight in UART_rcv are then handled from IDLE.

Optional Feature:
- Macro: TELEM_TIMEOUT_EN.
- Defined:
  - A counter clears on every accepted byte and increments while state != IDLE.
  - When it reaches TIMEOUT_CYC-1: state goes to IDLE, frm_err pulses once, outputs are unchanged.
  - Counter width is $clog2(TIMEOUT_CYC).
- Undefined: no counter exists and the FSM waits indefinitely for the next byte.

Decomposition:
- Package telemetry_pkg holds:
  - DELIM1/DELIM2 localparams;
  - typedef enum logic [1:0] {IDLE, WAIT_D2, PAYLOAD} telem_state_t;
  - PAYLOAD_BYTES=6.
- The telemetry transmitter shares telemetry_pkg.
- No sub-module; the optional timeout counter stays inline under `ifdef.

Test Plan:
- telemetry TX (batt_v=12'hABC, avg_curr=12'h123, avg_torque=12'h567) -> UART_rcv -> telemetry_rcv -> one pkt_vld with outputs ABC/123/567; frm_err stays 0.
- Two consecutive frames, the second with 12'h001/12'hFFF/12'h800 -> two pkt_vld pulses; outputs hold the first frame's values until the second pulse.
- Byte stream 0x12, 0xAA, 0xAA, 0x55 + 6 payload bytes -> 0x12 ignored, double 0xAA resyncs, one pkt_vld, no frm_err.
- Stream 0xAA, 0x55, 0x1A, ... (bad upper nibble) -> frm_err one cycle, no pkt_vld, outputs unchanged; a following valid frame decodes correctly.
- rst_n=0 for 2 cycles after payload byte 3 -> outputs 0, state IDLE; the next full frame decodes correctly.
- With TELEM_TIMEOUT_EN and TIMEOUT_CYC=100: send 0xAA, 0x55, 0x0A, then idle 100 cycles -> frm_err pulse, state IDLE; a subsequent full frame gives pkt_vld.
